ifetch_prefetch: RTL and testbench

- Fetch front-end that generates the instruction stream for the uniciclo core.
- Issues word requests to instruction memory over a valid/ready bus. The memory returns responses in order, with variable latency of at least 1 cycle.
- Buffers returned {pc, instr} pairs in a small FIFO and presents them to the core with a valid/ready handshake.
- Flushes the FIFO and discards stale in-flight responses when the core redirects control flow (taken branch).

---
 rtl/ifetch_prefetch.sv | 169 ++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_prefetch
// Brief   : Instruction fetch front-end: credit-limited word prefetch into a
//           {pc, instr} FIFO, with redirect flush of stale in-flight responses.
//           Optional performance counters when IFETCH_PERF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_flushes
`endif
);

  localparam int unsigned   c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   c_CW    = c_AW + 1;
  localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  logic [31:0]     r_fetch_pc;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_stale;
  logic [c_CW-1:0] r_count;
  logic [c_AW-1:0] r_pq_wr;
  logic [c_AW-1:0] r_pq_rd;
  logic [c_AW-1:0] r_wr;
  logic [c_AW-1:0] r_rd;
  logic [31:0]     r_pq_mem    [DEPTH];
  logic [31:0]     r_fifo_pc   [DEPTH];
  logic [31:0]     r_fifo_data [DEPTH];

  logic            w_credit_ok;
  logic            w_accept;
  logic            w_rsp_any;
  logic            w_rsp_live;
  logic            w_rsp_drop;
  logic            w_pop;
  logic [c_CW-1:0] w_out_next;
  logic [c_CW-1:0] w_stale_next;
  logic            w_unused;

  // Credit covers both in-flight requests and buffered entries, so the FIFO never overflows.
  assign w_credit_ok   = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_DEPTH;
  assign mem_req_valid = !rst && (r_state == S_FETCH) && !redirect_valid && w_credit_ok;
  assign mem_req_addr  = r_fetch_pc;

  assign w_accept   = mem_req_valid && mem_req_ready;
  assign w_rsp_any  = mem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_live = w_rsp_any && !redirect_valid && (r_stale == '0);
  assign w_rsp_drop = w_rsp_any && !w_rsp_live;

  assign instr_valid = (r_count != '0);
  assign instr_data  = instr_valid ? r_fifo_data[r_rd] : '0;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_rd]   : '0;
  assign w_pop       = instr_valid && instr_ready;

  assign w_out_next   = r_outstanding + c_CW'(w_accept) - c_CW'(w_rsp_any);
  // On a redirect every surviving in-flight response becomes stale.
  assign w_stale_next = redirect_valid ? w_out_next : (r_stale - c_CW'(w_rsp_drop));

  assign w_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_stale       <= '0;
      r_count       <= '0;
      r_pq_wr       <= '0;
      r_pq_rd       <= '0;
      r_wr          <= '0;
      r_rd          <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_stale       <= w_stale_next;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_count    <= '0;
        r_pq_wr    <= '0;
        r_pq_rd    <= '0;
        r_wr       <= '0;
        r_rd       <= '0;
        r_state    <= (w_stale_next != '0) ? S_FLUSH : S_FETCH;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_pq_wr    <= r_pq_wr + c_AW'(1);
        end
        if (w_rsp_live) begin
          r_pq_rd <= r_pq_rd + c_AW'(1);
          r_wr    <= r_wr + c_AW'(1);
        end
        if (w_pop) begin
          r_rd <= r_rd + c_AW'(1);
        end
        r_count <= r_count + c_CW'(w_rsp_live) - c_CW'(w_pop);
        if ((r_state == S_FLUSH) && (w_stale_next == '0)) begin
          r_state <= S_FETCH;
        end
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pq_mem[r_pq_wr] <= r_fetch_pc;
    end
    if (w_rsp_live) begin
      r_fifo_pc[r_wr]   <= r_pq_mem[r_pq_rd];
      r_fifo_data[r_wr] <= mem_rsp_data;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;
  logic [31:0] r_perf_flushes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != '1)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_rsp_drop && (r_perf_dropped != '1)) begin
        r_perf_dropped <= r_perf_dropped + 32'd1;
      end
      if (redirect_valid && (r_perf_flushes != '1)) begin
        r_perf_flushes <= r_perf_flushes + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch_prefetch
// Brief   : Directed + randomized bench for ifetch_prefetch with an in-order
//           variable-latency memory and an instruction-stream reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
  logic [31:0] perf_flushes;
`endif

  always #5 clk = ~clk;

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_flushes   (perf_flushes)
`endif
  );

  // Memory-side pending responses, tagged with the fetch epoch they belong to.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } rsp_t;

  rsp_t        rsp_q[$];
  int          cyc, epoch, buffered, last_due;
  logic [31:0] exp_pc, exp_req;
  int          m_fetched, m_dropped, m_flushes, m_accepts;
  int          n_checks, n_fail;
  int          p_mready, p_iready, lat_lo, lat_hi, pop_budget;
  bit          redir_now;
  logic [31:0] redir_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    epoch++;
    buffered  = 0;
    exp_pc    = RESET_PC;
    exp_req   = RESET_PC;
    m_fetched = 0;
    m_dropped = 0;
    m_flushes = 0;
    m_accepts = 0;
    last_due  = cyc;
  endtask

  // Asserts reset between edges, checks outputs immediately, releases after two edges.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    instr_ready    = 1'b0;
    #1;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, RESET_PC);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
`ifdef IFETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_dropped", perf_dropped, 32'd0);
    check("rst_perf_flushes", perf_flushes, 32'd0);
`endif
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict and check outputs, advance the model.
  task automatic step();
    bit   flushing;
    logic rv_exp;
    int   lat, due;
    rsp_t e;
    redirect_valid = redir_now;
    redirect_pc    = redir_target;
    redir_now      = 1'b0;
    mem_req_ready  = ($urandom_range(99) < p_mready);
    instr_ready    = (pop_budget != 0) && ($urandom_range(99) < p_iready);
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(rsp_q[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #1;
    flushing = 1'b0;
    foreach (rsp_q[i]) if (rsp_q[i].epoch != epoch) flushing = 1'b1;
    rv_exp = !redirect_valid && !flushing && ((rsp_q.size() + buffered) < DEPTH);
    check("mem_req_valid", 32'(mem_req_valid), 32'(rv_exp));
    check("instr_valid", 32'(instr_valid), 32'(buffered != 0));
    if (instr_valid && instr_ready) begin
      check("instr_pc", instr_pc, exp_pc);
      check("instr_data", instr_data, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      buffered--;
      m_fetched++;
      if (pop_budget > 0) pop_budget--;
    end
    if (mem_rsp_valid) begin
      e = rsp_q.pop_front();
      if (redirect_valid || e.epoch != epoch) m_dropped++;
      else buffered++;
    end
    if (redirect_valid) begin
      epoch++;
      buffered = 0;
      exp_pc   = {redirect_pc[31:2], 2'b00};
      exp_req  = {redirect_pc[31:2], 2'b00};
      m_flushes++;
    end
    if (mem_req_valid && mem_req_ready) begin
      check("mem_req_addr", mem_req_addr, exp_req);
      lat = int'($urandom_range(lat_hi, lat_lo));
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      rsp_q.push_back('{addr: mem_req_addr, epoch: epoch, due: due});
      exp_req = exp_req + 32'd4;
      m_accepts++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int first, f0, waited;
    bit found;
    cyc = 0; epoch = 0; n_checks = 0; n_fail = 0;
    p_mready = 100; p_iready = 100; lat_lo = 1; lat_hi = 1; pop_budget = -1;
    redir_now = 1'b0; redir_target = 32'd0; redirect_pc = 32'd0; mem_rsp_data = 32'd0;
    @(posedge clk);
    #1;

    // Streaming at 1-cycle latency: first valid two cycles after release, then gapless.
    do_reset();
    first = -1;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid && first < 0) first = i;
      step();
    end
    check("first_valid_latency", 32'(first), 32'd2);
    f0 = m_fetched;
    repeat (20) step();
    check("gapless_stream", 32'(m_fetched - f0), 32'd20);

    // Core stalled: exactly DEPTH requests, then drain in order.
    do_reset();
    p_iready = 0;
    repeat (12) step();
    check("stall_req_count", 32'(m_accepts), 32'(DEPTH));
    check("stall_fifo_valid", 32'(instr_valid), 32'd1);
    check("stall_head_pc", instr_pc, RESET_PC);
    p_iready = 100;
    repeat (8) step();
    check("stall_drained", 32'(m_fetched >= DEPTH), 32'd1);

    // Redirect to an unaligned target with two requests in flight at latency 3.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    step();
    step();
    redir_now = 1'b1; redir_target = 32'h0040_0001;
    step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        check("flush_first_pc", instr_pc, 32'h0040_0000);
      end
      step();
    end
    check("flush_delivered", 32'(found), 32'd1);
    check("flush_dropped", 32'(m_dropped), 32'd2);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();
    check("coinc_setup_valid", 32'(instr_valid), 32'd1);
    redir_now = 1'b1; redir_target = 32'h0050_0000;
    f0 = m_fetched;
    step();
    check("coinc_next_empty", 32'(instr_valid), 32'd0);
    check("coinc_pop_once", 32'(m_fetched - f0), 32'd1);
    repeat (10) step();

    // Reset in the middle of a flush; stale responses are withheld afterwards.
    do_reset();
    lat_lo = 6; lat_hi = 6;
    step();
    step();
    redir_now = 1'b1; redir_target = 32'h0060_0000;
    step();
    step();
    check("midflush_req_blocked", 32'(mem_req_valid), 32'd0);
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (12) step();
    check("restart_fetched", 32'(m_fetched > 0), 32'd1);

    // Five pops then one redirect dropping two responses.
    do_reset();
    lat_lo = 8; lat_hi = 8; pop_budget = 5;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_fetched == 5 && rsp_q.size() == 2) found = 1'b1;
      else step();
    end
    check("perf_setup", 32'(found), 32'd1);
    redir_now = 1'b1; redir_target = RESET_PC;
    step();
    waited = 0;
    while (rsp_q.size() > 0 && waited < 50) begin
      step();
      waited++;
    end
    step();
`ifdef IFETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd5);
    check("perf_dropped", perf_dropped, 32'd2);
    check("perf_flushes", perf_flushes, 32'd1);
`endif

    // Randomized traffic with occasional redirects, including near address wrap.
    do_reset();
    p_mready = 70; p_iready = 60; lat_lo = 1; lat_hi = 4; pop_budget = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        redir_now    = 1'b1;
        redir_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
      end
      step();
    end
`ifdef IFETCH_PERF_EN
    check("rand_perf_fetched", perf_fetched, 32'(m_fetched));
    check("rand_perf_dropped", perf_dropped, 32'(m_dropped));
    check("rand_perf_flushes", perf_flushes, 32'(m_flushes));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
